hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage 16-bit core. It produces the hold, bubble and flush controls consumed by the PC, IF/ID and ID/IX pipeline registers.
- It keeps a private shadow of in-flight destination registers for the EX and MEM stages and detects RAW hazards against the instruction in ID.
- It sequences data-memory wait stalls, branch/jump squashes and HALT drain.

Parameters:
- REG_W, 3, register index width (8 GPRs).
- FORWARDING, 0, 0 = stall on any EX/MEM RAW match; 1 = stall only on load-use against EX.
- DRAIN_CYC, 3, cycles after HALT enters EX until the pipe is empty.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs_used  in  1  ID reads rs.
- id_rs  in  REG_W  rs index.
- id_rt_used  in  1  ID reads rt.
- id_rt  in  REG_W  rt index.
- id_wr_en  in  1  ID instruction writes a register.
- id_wr_reg  in  REG_W  destination index.
- id_is_load  in  1  ID instruction is a load.
- id_halt  in  1  ID instruction is HALT.
- ex_redirect  in  1  EX resolved a taken branch or jump.
- mem_busy  in  1  data memory not ready; the whole pipe must freeze.
- STALL  out  1  hold PC and IF/ID.
- IX_STALL  out  1  hold ID/IX (drives its enable low).
- BUBBLE  out  1  ID/IX loads a NOP (ctrl = 0) instead of the ID values.
- FLUSH  out  1  squash IF/ID contents (load NOP).
- halted  out  1  core halted.

Behaviour:
- Reset is synchronous, clk only, active-high rst.
  - State on reset: RUN, both shadow entries invalid, drain counter = 0.
  - Resulting outputs: STALL = 0, IX_STALL = 0, BUBBLE = 0, FLUSH = 0, halted = 0.
  - rst overrides all other inputs in the same edge.
- Output timing: all outputs are combinational from the registered state, the shadow and the current inputs. There is zero added latency.
- Shadow entries: sh_ex and sh_mem, each holding {v, reg, load}.
- RAW hazard (haz) is true when id_valid is set and a source index with its used-bit set equals:
  - FORWARDING = 0: sh_ex.reg with sh_ex.v set, or sh_mem.reg with sh_mem.v set.
  - FORWARDING = 1: sh_ex.reg with sh_ex.v and sh_ex.load set.
  - WB writes are covered by the register file's write-before-read bypass, so WB is never checked.
- States are RUN, DRAIN and HALTED. Priority per cycle: rst > mem_busy > ex_redirect > haz > id_halt > normal.
- In RUN:
  - mem_busy: STALL = 1, IX_STALL = 1, BUBBLE = 0, FLUSH = 0. Shadow and state hold. ex_redirect is ignored because EX is frozen; it is seen again once busy drops.
  - ex_redirect: FLUSH = 1, BUBBLE = 1, STALL = 0. Shadow updates sh_mem <= sh_ex, sh_ex <= invalid. A haz or id_halt in the same cycle is discarded.
  - haz: STALL = 1, BUBBLE = 1, IX_STALL = 0. Shadow updates sh_mem <= sh_ex, sh_ex <= invalid. The hazard repeats each cycle until the matching entry ages out.
  - id_halt (id_valid set, no haz): HALT advances normally. State goes to DRAIN with counter = DRAIN_CYC.
  - normal: sh_mem <= sh_ex; sh_ex <= {id_valid & id_wr_en, id_wr_reg, id_is_load}.
- In DRAIN:
  - Outputs: STALL = 1, BUBBLE = 1.
  - Shadow ages each cycle, with invalid entries inserted.
  - Counter decrements when mem_busy = 0. While mem_busy = 1 it holds, and IX_STALL = 1, BUBBLE = 0.
  - When the counter reaches 1 and decrements, the next state is HALTED.
- In HALTED:
  - Outputs: STALL = 1, BUBBLE = 1, halted = 1.
  - All inputs are ignored until rst.
- An index match on an invalid shadow entry never stalls. Register 0 is an ordinary register (no hardwired zero).

Decomposition:
- Shared package hazard_pkg holds:
  - state encoding: RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2.
  - shadow entry width (REG_W + 2).
  - NOP control constant 16'h0000.
- One natural sub-module, hazard_shadow: the 2-deep shadow pipe.
  - Inputs: hold, insert_bubble, new entry.
  - Outputs: sh_ex, sh_mem.
  - The top level contains the match logic and the FSM.

Test Plan:
1. ADD r3 enters EX, then ID reads r3 (FORWARDING = 0) -> STALL = 1, BUBBLE = 1 for 2 cycles, then 0. On the third cycle ID advances.
2. FORWARDING = 1: LD r2 in EX, ID reads r2 -> exactly 1 stall cycle. ALU write to r2 followed by a read -> 0 stall cycles.
3. ex_redirect = 1 while ID has a hazard on r5 -> FLUSH = 1, BUBBLE = 1, STALL = 0 that cycle. The next cycle has no stall because sh_ex is invalid.
4. mem_busy held 4 cycles with ex_redirect = 1 -> IX_STALL = STALL = 1, FLUSH = 0 for 4 cycles. FLUSH = 1 on the cycle mem_busy drops.
5. HALT in ID with a clean pipe -> 3 DRAIN cycles (STALL = 1, BUBBLE = 1), then halted = 1 and it stays high. With mem_busy = 1 for 2 cycles during DRAIN, halted asserts 2 cycles later.
6. rst asserted during a haz stall and in HALTED -> all outputs 0 the following cycle and the shadow is empty. Reading r3 then causes no stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller: FSM states, shadow entry
// layout helpers and the NOP control word loaded on a bubble.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam int REG_W_DEF = 3;

  // Shadow entry layout, MSB to LSB: {v, reg[REG_W-1:0], load}.
  function automatic int sh_entry_w(input int reg_w);
    return reg_w + 2;
  endfunction

  localparam int SH_W_DEF = sh_entry_w(REG_W_DEF);

  // Control word the ID/IX register takes when BUBBLE is asserted.
  localparam logic [15:0] NOP_CTRL = 16'h0000;

endpackage

// File: rtl/hazard_shadow.sv
// Two-deep shadow of the destination registers in flight in EX and MEM.
// Ages one slot per cycle unless held; a bubble inserts an invalid entry.
module hazard_shadow
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hold_i,
  input  logic                    insert_bubble_i,
  input  logic [REG_W+1:0]        new_entry_i,
  output logic [REG_W+1:0]        sh_ex_o,
  output logic [REG_W+1:0]        sh_mem_o
);

  localparam int SH_W = sh_entry_w(REG_W);

  logic [SH_W-1:0] sh_ex_q, sh_ex_d;
  logic [SH_W-1:0] sh_mem_q, sh_mem_d;

  // Next shadow contents: hold, age with a bubble, or age with the ID entry.
  always_comb begin
    sh_ex_d  = sh_ex_q;
    sh_mem_d = sh_mem_q;
    if (!hold_i) begin
      sh_mem_d = sh_ex_q;
      sh_ex_d  = insert_bubble_i ? '0 : new_entry_i;
    end
  end

  // Shadow registers; reset clears both entries so nothing stalls afterwards.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      // NOTE: the whole entry is reset, not just v, so the shadow never holds X indices after reset.
      sh_ex_q  <= '0;
      sh_mem_q <= '0;
    end else begin
      sh_ex_q  <= sh_ex_d;
      sh_mem_q <= sh_mem_d;
    end
  end

  assign sh_ex_o  = sh_ex_q;
  assign sh_mem_o = sh_mem_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW detection against the EX/MEM shadow,
// memory-wait freeze, branch squash and HALT drain sequencing.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W      = REG_W_DEF,
  parameter int FORWARDING = 0,
  parameter int DRAIN_CYC  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_rs_used,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic             id_is_load,
  input  logic             id_halt,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             STALL,
  output logic             IX_STALL,
  output logic             BUBBLE,
  output logic             FLUSH,
  output logic             halted
);

  localparam int SH_W  = sh_entry_w(REG_W);
  localparam int CNT_W = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             sh_hold, sh_bubble;
  logic [SH_W-1:0]  new_entry, sh_ex, sh_mem;

  logic             ex_v, ex_load, mem_v;
  logic [REG_W-1:0] ex_reg, mem_reg;
  logic             ex_hit, mem_hit, haz;

  assign new_entry = {id_valid & id_wr_en, id_wr_reg, id_is_load};

  hazard_shadow #(.REG_W(REG_W)) u_shadow (
    .clk             (clk),
    .rst             (rst),
    .hold_i          (sh_hold),
    .insert_bubble_i (sh_bubble),
    .new_entry_i     (new_entry),
    .sh_ex_o         (sh_ex),
    .sh_mem_o        (sh_mem)
  );

  assign ex_v    = sh_ex[SH_W-1];
  assign ex_reg  = sh_ex[SH_W-2:1];
  assign ex_load = sh_ex[0];
  assign mem_v   = sh_mem[SH_W-1];
  assign mem_reg = sh_mem[SH_W-2:1];

  // Source-index match against each valid shadow slot; WB is covered by the regfile bypass.
  always_comb begin
    ex_hit  = ex_v  && ((id_rs_used && (id_rs == ex_reg))  || (id_rt_used && (id_rt == ex_reg)));
    mem_hit = mem_v && ((id_rs_used && (id_rs == mem_reg)) || (id_rt_used && (id_rt == mem_reg)));
    if (FORWARDING != 0) haz = id_valid && ex_hit && ex_load;
    else                 haz = id_valid && (ex_hit || mem_hit);
  end

  // Next state, drain counter, shadow control and pipeline controls.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_hold   = 1'b0;
    sh_bubble = 1'b1;
    STALL     = 1'b0;
    IX_STALL  = 1'b0;
    BUBBLE    = 1'b0;
    FLUSH     = 1'b0;
    halted    = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_busy) begin
          // Whole pipe frozen; a pending redirect is seen again once busy drops.
          STALL    = 1'b1;
          IX_STALL = 1'b1;
          sh_hold  = 1'b1;
        end else if (ex_redirect) begin
          FLUSH  = 1'b1;
          BUBBLE = 1'b1;
        end else if (haz) begin
          STALL  = 1'b1;
          BUBBLE = 1'b1;
        end else begin
          sh_bubble = 1'b0;
          if (id_valid && id_halt) begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(DRAIN_CYC);
          end
        end
      end
      DRAIN: begin
        STALL = 1'b1;
        if (mem_busy) begin
          IX_STALL = 1'b1;
          sh_hold  = 1'b1;
        end else begin
          BUBBLE = 1'b1;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = HALTED;
        end
      end
      HALTED: begin
        STALL  = 1'b1;
        BUBBLE = 1'b1;
        halted = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // FSM state and drain counter; rst wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: one instance per FORWARDING setting sharing stimulus.
// Directed table, hand-written halt/reset sequences, then random stimulus
// against a per-register busy-countdown reference model.
module tb_hazard_ctrl;

  localparam int REG_W     = 3;
  localparam int DRAIN_CYC = 3;
  localparam int N_RAND    = 3000;

  // Output bundle order: {STALL, IX_STALL, BUBBLE, FLUSH, halted}
  localparam logic [4:0] O_IDLE  = 5'b00000;
  localparam logic [4:0] O_HAZ   = 5'b10100;
  localparam logic [4:0] O_FLUSH = 5'b00110;
  localparam logic [4:0] O_BUSY  = 5'b11000;
  localparam logic [4:0] O_DRAIN = 5'b10100;
  localparam logic [4:0] O_HALT  = 5'b10101;

  logic clk = 1'b0;
  logic rst, id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, id_halt;
  logic ex_redirect, mem_busy;
  logic [REG_W-1:0] id_rs, id_rt, id_wr_reg;

  logic stall0, ixs0, bub0, fl0, hlt0;
  logic stall1, ixs1, bub1, fl1, hlt1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(REG_W), .FORWARDING(0), .DRAIN_CYC(DRAIN_CYC)) dut_fw0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_used(id_rs_used), .id_rs(id_rs),
    .id_rt_used(id_rt_used), .id_rt(id_rt), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
    .id_is_load(id_is_load), .id_halt(id_halt), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .STALL(stall0), .IX_STALL(ixs0), .BUBBLE(bub0), .FLUSH(fl0), .halted(hlt0)
  );

  hazard_ctrl #(.REG_W(REG_W), .FORWARDING(1), .DRAIN_CYC(DRAIN_CYC)) dut_fw1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_used(id_rs_used), .id_rs(id_rs),
    .id_rt_used(id_rt_used), .id_rt(id_rt), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
    .id_is_load(id_is_load), .id_halt(id_halt), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .STALL(stall1), .IX_STALL(ixs1), .BUBBLE(bub1), .FLUSH(fl1), .halted(hlt1)
  );

  typedef struct {
    string            name;
    logic             rst;
    logic             valid;
    logic             rs_used;
    logic [REG_W-1:0] rs;
    logic             rt_used;
    logic [REG_W-1:0] rt;
    logic             wr_en;
    logic [REG_W-1:0] wr_reg;
    logic             load;
    logic             halt;
    logic             redir;
    logic             busy;
    logic [4:0]       exp0;
    logic [4:0]       exp1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string name, logic valid, logic rs_used, logic [REG_W-1:0] rs,
                              logic rt_used, logic [REG_W-1:0] rt, logic wr_en,
                              logic [REG_W-1:0] wr_reg, logic load, logic halt, logic redir,
                              logic busy, logic [4:0] e0, logic [4:0] e1);
    vec_t v;
    v.name = name; v.rst = 1'b0; v.valid = valid; v.rs_used = rs_used; v.rs = rs;
    v.rt_used = rt_used; v.rt = rt; v.wr_en = wr_en; v.wr_reg = wr_reg; v.load = load;
    v.halt = halt; v.redir = redir; v.busy = busy; v.exp0 = e0; v.exp1 = e1;
    return v;
  endfunction

  function automatic vec_t mk_idle(string name, logic [4:0] e0, logic [4:0] e1);
    return mk(name, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e0, e1);
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {STALL,IX_STALL,BUBBLE,FLUSH,halted}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst = v.rst; id_valid = v.valid; id_rs_used = v.rs_used; id_rs = v.rs;
    id_rt_used = v.rt_used; id_rt = v.rt; id_wr_en = v.wr_en; id_wr_reg = v.wr_reg;
    id_is_load = v.load; id_halt = v.halt; ex_redirect = v.redir; mem_busy = v.busy;
    #1;
  endtask

  task automatic apply(input vec_t v, input bit chk);
    drive(v);
    if (chk) begin
      check({v.name, "_fw0"}, {stall0, ixs0, bub0, fl0, hlt0}, v.exp0);
      check({v.name, "_fw1"}, {stall1, ixs1, bub1, fl1, hlt1}, v.exp1);
    end
  endtask

  task automatic do_reset();
    vec_t v;
    v = mk_idle("rst", O_IDLE, O_IDLE);
    v.rst = 1'b1;
    apply(v, 1'b0);
  endtask

  // Reference model: per register, how many more cycles a reader of it must stall.
  int pend[2][8];
  int mode[2];      // 0 run, 1 drain, 2 halted
  int left[2];

  function automatic logic [4:0] model_out(int f);
    bit hit;
    hit = id_valid && ((id_rs_used && pend[f][id_rs] > 0) || (id_rt_used && pend[f][id_rt] > 0));
    if (mode[f] == 2) return O_HALT;
    if (mode[f] == 1) return mem_busy ? O_BUSY : O_DRAIN;
    if (mem_busy)     return O_BUSY;
    if (ex_redirect)  return O_FLUSH;
    if (hit)          return O_HAZ;
    return O_IDLE;
  endfunction

  task automatic model_age(int f);
    for (int r = 0; r < 8; r++) if (pend[f][r] > 0) pend[f][r]--;
  endtask

  task automatic model_step(int f);
    logic [4:0] o;
    o = model_out(f);
    if (rst) begin
      for (int r = 0; r < 8; r++) pend[f][r] = 0;
      mode[f] = 0;
      left[f] = 0;
    end else if (mode[f] == 0) begin
      if (o == O_FLUSH || o == O_HAZ) begin
        model_age(f);
      end else if (o == O_IDLE) begin
        model_age(f);
        if (id_valid && id_wr_en)
          pend[f][id_wr_reg] = (f == 0) ? 2 : (id_is_load ? 1 : 0);
        if (id_valid && id_halt) begin
          mode[f] = 1;
          left[f] = DRAIN_CYC;
        end
      end
    end else if (mode[f] == 1) begin
      if (!mem_busy) begin
        model_age(f);
        left[f]--;
        if (left[f] == 0) mode[f] = 2;
      end
    end
  endtask

  initial begin
    vec_t v;

    // Directed table; first row also checks the post-reset outputs.
    tbl.push_back(mk_idle("reset_state", O_IDLE, O_IDLE));
    tbl.push_back(mk("add_r3",     1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, O_IDLE, O_IDLE));
    tbl.push_back(mk("raw_r3_a",   1, 1, 3, 0, 0, 1, 4, 0, 0, 0, 0, O_HAZ,  O_IDLE));
    tbl.push_back(mk("raw_r3_b",   1, 1, 3, 0, 0, 1, 4, 0, 0, 0, 0, O_HAZ,  O_IDLE));
    tbl.push_back(mk("raw_r3_go",  1, 1, 3, 0, 0, 1, 4, 0, 0, 0, 0, O_IDLE, O_IDLE));
    tbl.push_back(mk("ld_r2",      1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, O_IDLE, O_IDLE));
    tbl.push_back(mk("use_r2_a",   1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, O_HAZ,  O_HAZ));
    tbl.push_back(mk("use_r2_b",   1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, O_HAZ,  O_IDLE));
    tbl.push_back(mk("use_r2_c",   1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, O_IDLE, O_IDLE));
    tbl.push_back(mk("alu_r2",     1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, O_IDLE, O_IDLE));
    tbl.push_back(mk("rd_r2",      1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, O_HAZ,  O_IDLE));
    tbl.push_back(mk_idle("gap_a", O_IDLE, O_IDLE));
    tbl.push_back(mk("alu_r5",     1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, O_IDLE, O_IDLE));
    tbl.push_back(mk("redir_haz",  1, 1, 5, 0, 0, 0, 0, 0, 1, 1, 0, O_FLUSH, O_FLUSH));
    tbl.push_back(mk("post_redir", 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, O_IDLE));
    tbl.push_back(mk("alu_r1",     1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, O_IDLE, O_IDLE));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk($sformatf("busy_%0d", k), 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, O_BUSY, O_BUSY));
    tbl.push_back(mk("busy_drop",  1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, O_FLUSH, O_FLUSH));
    tbl.push_back(mk_idle("gap_b", O_IDLE, O_IDLE));

    do_reset();
    foreach (tbl[i]) apply(tbl[i], 1'b1);

    // HALT with a clean pipe: three drain cycles, then halted sticks.
    do_reset();
    apply(mk("halt_issue", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_IDLE, O_IDLE), 1'b1);
    for (int k = 0; k < DRAIN_CYC; k++) apply(mk_idle($sformatf("drain_%0d", k), O_DRAIN, O_DRAIN), 1'b1);
    for (int k = 0; k < 3; k++) begin
      logic b;
      b = k[0];
      apply(mk($sformatf("halted_%0d", k), 1, 1, 3, 0, 0, 1, 3, 0, 1, b, ~b, O_HALT, O_HALT), 1'b1);
    end

    // rst in HALTED returns everything to idle.
    v = mk("rst_in_halt", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, O_IDLE, O_IDLE);
    v.rst = 1'b1;
    apply(v, 1'b0);
    apply(mk_idle("after_halt_rst", O_IDLE, O_IDLE), 1'b1);

    // HALT with two mem_busy cycles during drain: halted arrives two cycles later.
    apply(mk("halt_issue_b", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_IDLE, O_IDLE), 1'b1);
    for (int k = 0; k < 2; k++) apply(mk($sformatf("drain_busy_%0d", k), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_BUSY, O_BUSY), 1'b1);
    for (int k = 0; k < DRAIN_CYC; k++) apply(mk_idle($sformatf("drain_b_%0d", k), O_DRAIN, O_DRAIN), 1'b1);
    for (int k = 0; k < 2; k++) apply(mk_idle($sformatf("halted_b_%0d", k), O_HALT, O_HALT), 1'b1);

    // rst during a hazard stall empties the shadow.
    do_reset();
    apply(mk("alu_r3_c", 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, O_IDLE, O_IDLE), 1'b1);
    apply(mk("rd_r3_c",  1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, O_HAZ,  O_IDLE), 1'b1);
    v = mk("rst_in_haz", 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, O_IDLE);
    v.rst = 1'b1;
    apply(v, 1'b0);
    apply(mk("rd_r3_after_rst", 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, O_IDLE), 1'b1);

    // Random stimulus against the reference model.
    do_reset();
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 8; r++) pend[f][r] = 0;
      mode[f] = 0;
      left[f] = 0;
    end
    for (int c = 0; c < N_RAND; c++) begin
      int rst_pct;
      rst_pct = (mode[0] == 2 || mode[1] == 2) ? 15 : 1;
      v.name    = "rand";
      v.rst     = ($urandom_range(0, 99) < rst_pct);
      v.valid   = ($urandom_range(0, 99) < 85);
      v.rs_used = $urandom_range(0, 1);
      v.rs      = REG_W'($urandom_range(0, 3));
      v.rt_used = $urandom_range(0, 1);
      v.rt      = REG_W'($urandom_range(0, 3));
      v.wr_en   = ($urandom_range(0, 99) < 70);
      v.wr_reg  = REG_W'($urandom_range(0, 3));
      v.load    = $urandom_range(0, 1);
      v.halt    = ($urandom_range(0, 99) < 2);
      v.redir   = ($urandom_range(0, 99) < 8);
      v.busy    = ($urandom_range(0, 99) < 10);
      drive(v);
      if (!rst) begin
        check($sformatf("rand_fw0_c%0d", c), {stall0, ixs0, bub0, fl0, hlt0}, model_out(0));
        check($sformatf("rand_fw1_c%0d", c), {stall1, ixs1, bub1, fl1, hlt1}, model_out(1));
      end
      model_step(0);
      model_step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
